spm_mul_ctrl: RTL
=================

// Module: spm_mul_ctrl
// PURPOSE
//  Self-sequencing serial-parallel multiplier with parallel operand load and a parallel product register.
//  Signed (two's complement) or unsigned mode is selected per operation.
//  Valid/ready handshake on both input and output, so it drops into a datapath without bench-side shift registers.
//  Internally it has a carry-save serial-parallel array: X is parallel, Y is shifted in LSB-first, and product bits emerge LSB-first.
// PARAMETERS
//  XW  8  width of parallel operand x (>=2)
//  YW  8  width of serial operand y (>=2)
//  PW  XW+YW  product width (derived localparam, not overridable)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   operands present
//  in_ready   out  1   block can accept operands this cycle
//  x          in   XW  parallel multiplicand
//  y          in   YW  multiplier (serialised internally)
//  sgn        in   1   1 = both operands signed, 0 = both unsigned; sampled with operands
//  out_valid  out  1   product valid; held until consumed
//  out_ready  in   1   consumer accepts product
//  prod       out  PW  product, x*y mod 2^PW in the selected interpretation
//  busy       out  1   high in RUN
//  p_bit      out  1   current serial product bit (debug/legacy serial tap)
// BEHAVIOUR
//  Reset (rst=1 at posedge) clears all state.
//  - Outputs after reset: state=IDLE, in_ready=1, out_valid=0, busy=0, prod=0, p_bit=0.
//  - Array carries, y shifter and bit counter are cleared.
//  - Reset overrides everything, including mid-RUN. A partial result is discarded and never presented.
//  FSM states: IDLE, RUN, DONE.
//  - IDLE: in_ready=1. On in_valid, the block latches x, y and sgn, clears array carries, zeroes cnt, and goes to RUN.
//  - RUN: one product bit per cycle, for PW cycles (cnt 0..PW-1). On the edge where cnt==PW-1 it goes to DONE.
//  - DONE: out_valid=1 and prod is stable. On out_ready it goes to IDLE, or straight back to RUN if in_valid is also accepted.
//  in_ready = (state==IDLE) || (state==DONE && out_ready).
//  - Operands offered while in RUN, or in DONE without out_ready, are not accepted.
//  - The source must hold x, y and sgn stable until accepted.
//  - Back-to-back operation: in DONE with out_ready=1 and in_valid=1 on the same edge, the product is consumed, new operands are latched, and the FSM goes to RUN with no idle cycle.
//  Latency: out_valid rises exactly PW clock edges after the accepting edge. Throughput is one product per PW+1 cycles with out_ready held high.
//  Serial y stream: y[0..YW-1] LSB-first, then PW-YW extension bits.
//  - Extension bits are y[YW-1] when sgn=1, 0 when sgn=0.
//  Parallel x:
//  - sgn=1: the MSB cell carries negative weight (subtract), i.e. x is sign-extended.
//  - sgn=0: all cells carry positive weight.
//  Product capture: each RUN cycle shifts p_bit into prod from the MSB side. After PW bits, prod[0] is the first bit produced.
//  - prod changes only in RUN. It holds its value in DONE and IDLE until the next accept.
//  Width rule: the result is truncated to PW bits. It is exact for all operand values in both modes, including the most-negative x and y.
//  busy=1 exactly when state==RUN. p_bit is the array output bit in RUN and 0 otherwise.
//  sgn, x and y changing during RUN have no effect, because latched copies are used.
// TESTING
//  (XW=YW=8, PW=16)
//  1. Unsigned: x=50, y=50, sgn=0 -> prod=16'd2500. out_valid exactly 16 cycles after accept; busy high for 16 cycles.
//  2. Signed mixes, sgn=1:
//     - x=-9, y=80 -> 16'hFD30 (-720).
//     - x=-9, y=-80 -> 16'd720.
//     - x=-128, y=-128 -> 16'h4000.
//     - x=25, y=65 -> 16'd1625.
//  3. Unsigned extremes, sgn=0: x=255, y=255 -> 16'hFE01. Same bits with sgn=1 (-1*-1) -> 16'h0001.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//     - prod and out_valid stay stable; in_ready=0.
//     - in_valid with new operands is not taken. Then out_ready=1 and in_valid=1 on the same cycle -> next op accepted, RUN entered next cycle.
//     - Second result is correct.
//  5. Mid-op events: in_valid pulsed with x=3, y=3 during RUN -> ignored; the first result is unaffected.
//     - rst asserted for 1 cycle at RUN cycle 7 -> next cycle: state IDLE, in_ready=1, out_valid=0, prod=0.
//     - A fresh op afterwards (x=7, y=6, sgn=0) -> 16'd42.
//  6. Random: 1000 ops with random x, y, sgn and random out_ready stalls -> all match the reference model x*y mod 2^16. No lost or duplicated products.

Source files
------------

// File: rtl/spm_mul_ctrl.sv
`timescale 1ns/1ps
// Self-sequencing serial-parallel multiplier with parallel x, serial y (LSB-first) and parallel product.
// Latency: out_valid rises XW+YW edges after the accepting edge; one product per XW+YW+1 cycles.
// Backpressure: product held in DONE until out_ready; operands refused while RUN or stalled DONE.
module spm_mul_ctrl #(
   parameter int XW = 8,
   parameter int YW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XW-1:0]      x,
   input  logic [YW-1:0]      y,
   input  logic               sgn,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XW+YW-1:0]   prod,
   output logic               busy,
   output logic               p_bit
);

   localparam int PW = XW + YW;
   localparam int CW = $clog2(PW);
   localparam logic [CW-1:0] LAST = CW'(PW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic            r_sgn;
   logic [CW-1:0]   r_cnt;
   logic [XW:0]     r_acc;     // partial-sum state of the array, two's complement
   logic [PW-1:0]   r_prod;
   logic            r_out_valid;
   logic            r_busy;

   logic            w_ybit;
   logic            w_yfill;
   logic [XW:0]     w_xext;
   logic [XW+1:0]   w_pp;
   logic [XW+1:0]   w_sum;
   logic            w_accept;

   // Current serial y bit is always the shifter LSB; the shifter refills with the
   // sign bit in signed mode, so after YW shifts it emits the sign extension.
   assign w_ybit  = r_y[0];
   assign w_yfill = r_sgn & r_y[YW-1];

   // In signed mode x is sign-extended, which gives the MSB cell its negative weight.
   assign w_xext  = {r_sgn & r_x[XW-1], r_x};
   assign w_pp    = w_ybit ? {w_xext[XW], w_xext} : '0;
   assign w_sum   = {r_acc[XW], r_acc} + w_pp;

   assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign prod      = r_prod;
   assign p_bit     = r_busy & w_sum[0];

   // Sequencer plus datapath: load on accept, one product bit per RUN cycle, hold in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_sgn       <= 1'b0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_prod      <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x     <= x;
                  r_y     <= y;
                  r_sgn   <= sgn;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_acc  <= w_sum[XW+1:1];
               r_y    <= {w_yfill, r_y[YW-1:1]};
               r_prod <= {w_sum[0], r_prod[PW-1:1]};
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (in_valid) begin
                     // consume and reload on the same edge: no idle cycle
                     r_x     <= x;
                     r_y     <= y;
                     r_sgn   <= sgn;
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= RUN;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
